// File: rtl/div_ratio_sched.sv
`default_nettype none
// ============================================================================
// Module   : div_ratio_sched
// Brief    : Integer clock-divider sequencer with two-requester ratio arbiter;
//            new ratios take effect only on a divided-period boundary.
// Revision : 1.0
// ============================================================================
module div_ratio_sched #(
    parameter int CW      = 8,
    parameter int DEF_DIV = 3,
    parameter int MIN_DIV = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          req_a_valid,
    input  logic [CW-1:0] req_a_div,
    output logic          req_a_ready,
    input  logic          req_b_valid,
    input  logic [CW-1:0] req_b_div,
    output logic          req_b_ready,
    output logic          div_out,
    output logic          div_tick,
    output logic [CW-1:0] cur_div,
    output logic          busy,
    output logic          err
);

    localparam logic [CW-1:0] C_DEF  = CW'(DEF_DIV);
    localparam logic [CW-1:0] C_MIN  = CW'(MIN_DIV);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_ZERO = '0;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_cur_div;
    logic [CW-1:0] r_pend_div;
    logic          r_err;
    logic          r_prio_b;

    logic          w_grant_ok;
    logic          w_gnt_a;
    logic          w_gnt_b;
    logic          w_acc;
    logic [CW-1:0] w_req_div;
    logic          w_legal;
    logic          w_acc_legal;
    logic          w_wrap;
    logic [CW-1:0] w_cnt_next;

    // r_prio_b=1 means B wins a tie; it flips toward the other side on each grant.
    always_comb begin
        w_grant_ok  = (r_state != ST_PEND);
        w_gnt_a     = w_grant_ok && req_a_valid && (!req_b_valid || !r_prio_b);
        w_gnt_b     = w_grant_ok && req_b_valid && (!req_a_valid ||  r_prio_b);
        w_acc       = w_gnt_a || w_gnt_b;
        w_req_div   = w_gnt_a ? req_a_div : req_b_div;
        w_legal     = (w_req_div >= C_MIN);
        w_acc_legal = w_acc && w_legal;
        w_wrap      = (r_cnt == (r_cur_div - C_ONE));
        w_cnt_next  = w_wrap ? C_ZERO : (r_cnt + C_ONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_STOP;
            r_cnt      <= C_ZERO;
            r_cur_div  <= C_DEF;
            r_pend_div <= C_DEF;
            r_err      <= 1'b0;
            r_prio_b   <= 1'b0;
        end else begin
            r_err <= w_acc && !w_legal;
            if (w_gnt_a)
                r_prio_b <= 1'b1;
            else if (w_gnt_b)
                r_prio_b <= 1'b0;

            case (r_state)
                ST_STOP: begin
                    r_cnt <= C_ZERO;
                    if (w_acc_legal)
                        r_cur_div <= w_req_div;
                    if (en)
                        r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!en) begin
                        r_state <= ST_STOP;
                        r_cnt   <= C_ZERO;
                        if (w_acc_legal)
                            r_cur_div <= w_req_div;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_acc_legal) begin
                            r_pend_div <= w_req_div;
                            r_state    <= ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    // Stopping commits the pending ratio so it is not lost.
                    if (!en) begin
                        r_state   <= ST_STOP;
                        r_cnt     <= C_ZERO;
                        r_cur_div <= r_pend_div;
                    end else if (w_wrap) begin
                        r_state   <= ST_RUN;
                        r_cnt     <= C_ZERO;
                        r_cur_div <= r_pend_div;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                default: begin
                    r_state <= ST_STOP;
                    r_cnt   <= C_ZERO;
                end
            endcase
        end
    end

    assign req_a_ready = w_gnt_a;
    assign req_b_ready = w_gnt_b;
    assign div_out     = (r_state != ST_STOP) && (r_cnt < (r_cur_div >> 1));
    assign div_tick    = (r_state != ST_STOP) && (r_cnt == C_ZERO);
    assign cur_div     = r_cur_div;
    assign busy        = (r_state == ST_PEND);
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_div_ratio_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_ratio_sched
// Brief    : Directed self-checking bench for div_ratio_sched.
// Revision : 1.0
// ============================================================================
module tb_div_ratio_sched;

    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          en;
    logic          req_a_valid;
    logic [CW-1:0] req_a_div;
    logic          req_a_ready;
    logic          req_b_valid;
    logic [CW-1:0] req_b_div;
    logic          req_b_ready;
    logic          div_out;
    logic          div_tick;
    logic [CW-1:0] cur_div;
    logic          busy;
    logic          err;

    int checks = 0;
    int errors = 0;

    div_ratio_sched #(.CW(CW), .DEF_DIV(3), .MIN_DIV(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req_a_valid (req_a_valid),
        .req_a_div   (req_a_div),
        .req_a_ready (req_a_ready),
        .req_b_valid (req_b_valid),
        .req_b_div   (req_b_div),
        .req_b_ready (req_b_ready),
        .div_out     (div_out),
        .div_tick    (div_tick),
        .cur_div     (cur_div),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are observed 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0;
        req_a_valid = 1'b0; req_a_div = '0;
        req_b_valid = 1'b0; req_b_div = '0;
        repeat (2) step();
        checks++; if (cur_div !== 8'd3) begin errors++; $display("FAIL reset_cur_div got=%0d exp=3", cur_div); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (div_out !== 1'b0) begin errors++; $display("FAIL reset_div_out got=%b exp=0", div_out); end
        checks++; if (div_tick !== 1'b0) begin errors++; $display("FAIL reset_div_tick got=%b exp=0", div_tick); end
        rst = 1'b1;
        step();
        checks++; if (div_tick !== 1'b0) begin errors++; $display("FAIL stop_idle_tick got=%b exp=0", div_tick); end
    endtask

    task automatic test_run_n3();
        logic exp_out, exp_tick;
        en = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            exp_out  = ((k % 3) == 0);
            exp_tick = ((k % 3) == 0);
            checks++; if (div_out !== exp_out) begin errors++; $display("FAIL n3_div_out k=%0d got=%b exp=%b", k, div_out, exp_out); end
            checks++; if (div_tick !== exp_tick) begin errors++; $display("FAIL n3_div_tick k=%0d got=%b exp=%b", k, div_tick, exp_tick); end
            checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL n3_busy_err k=%0d got=%b%b exp=00", k, busy, err); end
            step();
        end
    endtask

    // Entered at cnt=0 of an N=3 period.
    task automatic test_ratio_change();
        logic exp_out, exp_tick;
        req_a_valid = 1'b1; req_a_div = 8'd4;
        #1;
        checks++; if (req_a_ready !== 1'b1) begin errors++; $display("FAIL chg_a_ready got=%b exp=1", req_a_ready); end
        step();
        req_a_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL chg_busy_c1 got=%b exp=1", busy); end
        checks++; if (cur_div !== 8'd3) begin errors++; $display("FAIL chg_cur_c1 got=%0d exp=3", cur_div); end
        checks++; if (div_out !== 1'b0) begin errors++; $display("FAIL chg_out_c1 got=%b exp=0", div_out); end
        step();
        checks++; if (cur_div !== 8'd3 || busy !== 1'b1) begin errors++; $display("FAIL chg_c2 got cur=%0d busy=%b exp cur=3 busy=1", cur_div, busy); end
        step();
        checks++; if (cur_div !== 8'd4) begin errors++; $display("FAIL chg_commit_cur got=%0d exp=4", cur_div); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL chg_commit_busy got=%b exp=0", busy); end
        for (int k = 0; k < 8; k++) begin
            exp_out  = ((k % 4) < 2);
            exp_tick = ((k % 4) == 0);
            checks++; if (div_out !== exp_out) begin errors++; $display("FAIL n4_div_out k=%0d got=%b exp=%b", k, div_out, exp_out); end
            checks++; if (div_tick !== exp_tick) begin errors++; $display("FAIL n4_div_tick k=%0d got=%b exp=%b", k, div_tick, exp_tick); end
            step();
        end
    endtask

    // Entered at cnt=0 of an N=4 period.
    task automatic test_pend_block();
        req_a_valid = 1'b1; req_a_div = 8'd5;
        #1;
        checks++; if (req_a_ready !== 1'b1) begin errors++; $display("FAIL pb_first_ready got=%b exp=1", req_a_ready); end
        step();
        req_a_div = 8'd2;
        for (int c = 1; c < 4; c++) begin
            #1;
            checks++; if (req_a_ready !== 1'b0) begin errors++; $display("FAIL pb_ready_in_pend cnt=%0d got=%b exp=0", c, req_a_ready); end
            step();
        end
        checks++; if (cur_div !== 8'd5 || busy !== 1'b0) begin errors++; $display("FAIL pb_commit1 got cur=%0d busy=%b exp cur=5 busy=0", cur_div, busy); end
        checks++; if (req_a_ready !== 1'b1) begin errors++; $display("FAIL pb_ready_after got=%b exp=1", req_a_ready); end
        step();
        req_a_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pb_busy2 got=%b exp=1", busy); end
        repeat (3) step();
        checks++; if (cur_div !== 8'd5 || div_out !== 1'b0) begin errors++; $display("FAIL pb_last_n5 got cur=%0d out=%b exp cur=5 out=0", cur_div, div_out); end
        step();
        checks++; if (cur_div !== 8'd2 || div_tick !== 1'b1 || div_out !== 1'b1) begin errors++; $display("FAIL pb_commit2 got cur=%0d tick=%b out=%b exp 2 1 1", cur_div, div_tick, div_out); end
        step();
        checks++; if (div_out !== 1'b0 || div_tick !== 1'b0) begin errors++; $display("FAIL n2_second got out=%b tick=%b exp 0 0", div_out, div_tick); end
        step();
    endtask

    task automatic test_err();
        req_b_valid = 1'b1; req_b_div = 8'd1;
        #1;
        checks++; if (req_b_ready !== 1'b1) begin errors++; $display("FAIL err1_ready got=%b exp=1", req_b_ready); end
        step();
        checks++; if (err !== 1'b1 || busy !== 1'b0 || cur_div !== 8'd2) begin errors++; $display("FAIL err1 got err=%b busy=%b cur=%0d exp 1 0 2", err, busy, cur_div); end
        req_b_div = 8'd0;
        #1;
        checks++; if (req_b_ready !== 1'b1) begin errors++; $display("FAIL err0_ready got=%b exp=1", req_b_ready); end
        step();
        req_b_valid = 1'b0;
        checks++; if (err !== 1'b1 || busy !== 1'b0 || cur_div !== 8'd2) begin errors++; $display("FAIL err0 got err=%b busy=%b cur=%0d exp 1 0 2", err, busy, cur_div); end
        step();
        checks++; if (err !== 1'b0 || cur_div !== 8'd2 || busy !== 1'b0) begin errors++; $display("FAIL err_clear got err=%b cur=%0d busy=%b exp 0 2 0", err, cur_div, busy); end
    endtask

    task automatic test_back_to_back();
        en = 1'b0;
        step();
        checks++; if (div_out !== 1'b0 || div_tick !== 1'b0) begin errors++; $display("FAIL stop_outs got out=%b tick=%b exp 0 0", div_out, div_tick); end
        req_a_valid = 1'b1; req_a_div = 8'd5;
        req_b_valid = 1'b1; req_b_div = 8'd6;
        #1;
        checks++; if (req_a_ready !== 1'b1 || req_b_ready !== 1'b0) begin errors++; $display("FAIL rr1 got a=%b b=%b exp a=1 b=0", req_a_ready, req_b_ready); end
        step();
        checks++; if (cur_div !== 8'd5) begin errors++; $display("FAIL rr1_cur got=%0d exp=5", cur_div); end
        checks++; if (req_a_ready !== 1'b0 || req_b_ready !== 1'b1) begin errors++; $display("FAIL rr2 got a=%b b=%b exp a=0 b=1", req_a_ready, req_b_ready); end
        step();
        checks++; if (cur_div !== 8'd6) begin errors++; $display("FAIL rr2_cur got=%0d exp=6", cur_div); end
        checks++; if (req_a_ready !== 1'b1 || req_b_ready !== 1'b0) begin errors++; $display("FAIL rr3 got a=%b b=%b exp a=1 b=0", req_a_ready, req_b_ready); end
        step();
        req_a_valid = 1'b0; req_b_valid = 1'b0;
        checks++; if (cur_div !== 8'd5 || busy !== 1'b0 || div_out !== 1'b0) begin errors++; $display("FAIL rr3_cur got cur=%0d busy=%b out=%b exp 5 0 0", cur_div, busy, div_out); end
    endtask

    task automatic test_rst_pend();
        en = 1'b1;
        step();
        req_a_valid = 1'b1; req_a_div = 8'd7;
        step();
        req_a_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rp_busy got=%b exp=1", busy); end
        rst = 1'b0;
        step();
        checks++; if (cur_div !== 8'd3 || busy !== 1'b0 || div_out !== 1'b0 || div_tick !== 1'b0) begin errors++; $display("FAIL rp_reset got cur=%0d busy=%b out=%b tick=%b exp 3 0 0 0", cur_div, busy, div_out, div_tick); end
        rst = 1'b1;
        step();
        checks++; if (cur_div !== 8'd3 || div_tick !== 1'b1 || div_out !== 1'b1) begin errors++; $display("FAIL rp_restart got cur=%0d tick=%b out=%b exp 3 1 1", cur_div, div_tick, div_out); end
    endtask

    // Entered at cnt=0 of an N=3 period with the pointer favouring A.
    task automatic test_en_pend();
        req_a_valid = 1'b1; req_a_div = 8'd7;
        #1;
        checks++; if (req_a_ready !== 1'b1) begin errors++; $display("FAIL ep_ready got=%b exp=1", req_a_ready); end
        step();
        req_a_valid = 1'b0;
        checks++; if (busy !== 1'b1 || cur_div !== 8'd3) begin errors++; $display("FAIL ep_pend got busy=%b cur=%0d exp 1 3", busy, cur_div); end
        en = 1'b0;
        step();
        checks++; if (cur_div !== 8'd7 || busy !== 1'b0 || div_out !== 1'b0 || div_tick !== 1'b0) begin errors++; $display("FAIL ep_stop got cur=%0d busy=%b out=%b tick=%b exp 7 0 0 0", cur_div, busy, div_out, div_tick); end
    endtask

    initial begin
        test_reset();
        test_run_n3();
        test_ratio_change();
        test_pend_block();
        test_err();
        test_back_to_back();
        test_rst_pend();
        test_en_pend();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_ratio_sched.md
Name: div_ratio_sched

Overview:
- Sequencing and configuration controller for the integer clock-divider datapath.
- Owns the divide ratio and arbitrates ratio-change requests from two requesters (A = software config, B = automatic/performance controller).
- Applies a new ratio only at a divided-period boundary, so the divided output never has a truncated or stretched period.
- Produces a single-clock-domain divided level (div_out) and a period-start strobe (div_tick) for downstream enable-based logic.

Parameters:
- CW, 8, width of the ratio and period counter.
- DEF_DIV, 3, ratio loaded at reset (must be >= MIN_DIV and < 2^CW).
- MIN_DIV, 2, smallest legal ratio; smaller requests are rejected.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- en  input  1  run enable for the divider.
- req_a_valid  input  1  requester A has a ratio.
- req_a_div  input  CW  requester A ratio.
- req_a_ready  output  1  A request accepted this cycle.
- req_b_valid  input  1  requester B has a ratio.
- req_b_div  input  CW  requester B ratio.
- req_b_ready  output  1  B request accepted this cycle.
- div_out  output  1  divided level.
- div_tick  output  1  one-cycle strobe on the first cycle of each divided period.
- cur_div  output  CW  ratio currently in effect.
- busy  output  1  an accepted ratio is waiting for a boundary.
- err  output  1  one-cycle pulse: the last accepted request was illegal (< MIN_DIV) and was discarded.

Behaviour:
- Reset (rst=0 at an edge):
  - state=STOP, cnt=0, cur_div=DEF_DIV, busy=0, err=0.
  - Round-robin pointer favours A.
  - div_out=0, div_tick=0.
  - Reset overrides everything, including an in-flight pending ratio, which is discarded.
- States:
  - STOP: cnt held at 0; div_out=0; div_tick=0.
    - en=1 -> RUN; cnt=0 on the first RUN cycle.
  - RUN: cnt increments each cycle and wraps from cur_div-1 to 0.
  - PEND: same counting as RUN, plus pend_div is held.
    - At the edge where cnt==cur_div-1: cur_div<=pend_div, cnt<=0, state<=RUN.
- Period decodes (from registered cnt/cur_div):
  - div_out=1 when state!=STOP and cnt < (cur_div>>1), else 0. Examples: N=2 gives 1/1; N=3 gives 1 high, 2 low; N=4 gives 2/2.
  - div_tick=1 when state!=STOP and cnt==0.
- en=0 while in RUN or PEND:
  - Next cycle is STOP with cnt=0.
  - A pending ratio is committed to cur_div at that same edge; busy clears.
- Arbitration and handshake:
  - ready is combinational; all other outputs are decodes of registers.
  - A grant is issued only when state!=PEND.
  - If only one requester is valid, it is granted.
  - If both are valid, the grant goes to the one not granted last; the pointer updates on every grant.
  - Transfer occurs when valid & ready at the edge. At most one grant per cycle.
- Accepted legal ratio (>= MIN_DIV):
  - In STOP: cur_div updates at the next edge; state stays STOP.
  - In RUN: pend_div is captured and state goes to PEND; busy=1 from the next cycle until the commit edge.
- Accepted illegal ratio (< MIN_DIV, including 0): handshake completes, value is dropped, err=1 for exactly one cycle after acceptance, state unchanged.
- Requests are never accepted in PEND, including the commit cycle. Requesters hold valid and data until ready.
- Equal-ratio request: processed normally (goes through PEND); there is no visible change in period.

Test Plan:
- Reset, en=1, no requests -> cur_div=3; div_out pattern 1,0,0 repeating; div_tick on every cnt=0; busy=0, err=0.
- In RUN with N=3, A requests 4 at cnt=0 -> busy=1; current 3-cycle period completes; then periods of 4 with div_out 1,1,0,0; cur_div changes exactly at the boundary; busy then 0.
- A and B both valid continuously (5 and 6), with en=0 -> grants alternate A, B, A; cur_div follows 5, 6, 5 on consecutive cycles.
- In RUN, a new A request arrives while in PEND -> req_a_ready=0 until the commit edge plus one cycle; second ratio is applied at the following boundary.
- B requests 1, then 0 -> each is accepted; err pulses one cycle each; cur_div and the period are unchanged.
- rst=0 mid-PEND, or en=0 mid-PEND with pend_div=7:
  - With rst: cur_div=3 and the pending value is lost.
  - With en=0: STOP, div_out=0, cur_div=7, busy=0.
